// File: rtl/vga_status_pkg.sv
// ============================================================================
// Module   : vga_status_pkg
// Purpose  : Game status codes and 640x480 VGA timing shared by producer/display.
// Revision : 1.0
// ============================================================================
`default_nettype none

package vga_status_pkg;

  typedef enum logic [1:0] {
    ST_HIT     = 2'd0,
    ST_RUNNING = 2'd1,
    ST_FAIL    = 2'd2,
    ST_ENDING  = 2'd3
  } status_e;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

  localparam int CNT_W = 10;

  // Only hit and fail start a flash sequence.
  function automatic logic is_flash_code(status_e s);
    return (s == ST_HIT) || (s == ST_FAIL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing.sv
// ============================================================================
// Module   : vga_timing
// Purpose  : Pixel enable, h/v counters, registered syncs and active flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_timing
  import vga_status_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FRONT  = VGA_H_FRONT,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BACK   = VGA_H_BACK,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FRONT  = VGA_V_FRONT,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BACK   = VGA_V_BACK
) (
  input  logic             clock_i,
  input  logic             rst_ni,
  output logic             pix_en_o,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             active_o,
  output logic             frame_end_o
);

  localparam logic [CNT_W-1:0] c_h_last   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] c_v_last   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CNT_W-1:0] c_hs_first = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] c_hs_last  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] c_vs_first = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] c_vs_last  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [CNT_W-1:0] c_h_active = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_v_active = CNT_W'(V_ACTIVE);

  logic             pix_en_q;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             hsync_q, vsync_q;

  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == c_h_last) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == c_v_last) ? '0 : v_cnt_q + CNT_W'(1);
    end
  end

  // Syncs are sampled from the pre-advance count, so they lag the counters by one pixel.
  always_ff @(posedge clock_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pix_en_q <= 1'b0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
    end else begin
      pix_en_q <= ~pix_en_q;
      if (pix_en_q) begin
        h_cnt_q <= h_cnt_d;
        v_cnt_q <= v_cnt_d;
        hsync_q <= ~((h_cnt_q >= c_hs_first) && (h_cnt_q <= c_hs_last));
        vsync_q <= ~((v_cnt_q >= c_vs_first) && (v_cnt_q <= c_vs_last));
      end
    end
  end

  assign pix_en_o    = pix_en_q;
  assign h_cnt_o     = h_cnt_q;
  assign v_cnt_o     = v_cnt_q;
  assign hsync_o     = hsync_q;
  assign vsync_o     = vsync_q;
  assign active_o    = (h_cnt_q < c_h_active) && (v_cnt_q < c_v_active);
  assign frame_end_o = pix_en_q && (h_cnt_q == c_h_last) && (v_cnt_q == c_v_last);

endmodule

`default_nettype wire

// File: rtl/vga_status_display.sv
// ============================================================================
// Module   : vga_status_display
// Purpose  : Renders game status (border / flash / full colour) on a VGA screen.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_status_display
  import vga_status_pkg::*;
#(
  parameter int FLASH_FRAMES = 30,
  parameter int BORDER_PX    = 16,
  parameter int H_ACTIVE     = VGA_H_ACTIVE,
  parameter int H_FRONT      = VGA_H_FRONT,
  parameter int H_SYNC       = VGA_H_SYNC,
  parameter int H_BACK       = VGA_H_BACK,
  parameter int V_ACTIVE     = VGA_V_ACTIVE,
  parameter int V_FRONT      = VGA_V_FRONT,
  parameter int V_SYNC       = VGA_V_SYNC,
  parameter int V_BACK       = VGA_V_BACK
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] result,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       frame_start
);

  // At least three bits so the flash phase bit always exists.
  localparam int FW = ($clog2(FLASH_FRAMES + 1) < 3) ? 3 : $clog2(FLASH_FRAMES + 1);

  localparam logic [FW-1:0]    c_flash_load  = FW'(FLASH_FRAMES);
  localparam logic [CNT_W-1:0] c_border      = CNT_W'(BORDER_PX);
  localparam logic [CNT_W-1:0] c_h_border_hi = CNT_W'(H_ACTIVE - BORDER_PX);
  localparam logic [CNT_W-1:0] c_v_border_hi = CNT_W'(V_ACTIVE - BORDER_PX);

  logic             pix_en, active, frame_end;
  logic [CNT_W-1:0] h_cnt, v_cnt;

  status_e          disp_state_q, disp_state_d;
  logic [FW-1:0]    flash_cnt_q, flash_cnt_d;
  logic             frame_start_q;
  logic [11:0]      rgb_q, rgb_d;
  logic             flash_on, in_border;
  status_e          sampled;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) u_timing (
    .clock_i     (clock),
    .rst_ni      (reset),
    .pix_en_o    (pix_en),
    .h_cnt_o     (h_cnt),
    .v_cnt_o     (v_cnt),
    .hsync_o     (hsync),
    .vsync_o     (vsync),
    .active_o    (active),
    .frame_end_o (frame_end)
  );

  assign sampled = status_e'(result);

  // Status is latched only at the last pixel of a frame so a frame never changes mid-scan.
  always_comb begin
    disp_state_d = disp_state_q;
    flash_cnt_d  = flash_cnt_q;
    if (frame_end) begin
      disp_state_d = sampled;
      if (is_flash_code(sampled) && (sampled != disp_state_q)) begin
        flash_cnt_d = c_flash_load;
      end else if (flash_cnt_q != '0) begin
        flash_cnt_d = flash_cnt_q - FW'(1);
      end
    end
  end

  assign flash_on  = (flash_cnt_q != '0) && flash_cnt_q[2];
  assign in_border = (h_cnt < c_border) || (h_cnt >= c_h_border_hi) ||
                     (v_cnt < c_border) || (v_cnt >= c_v_border_hi);

  always_comb begin
    rgb_d = 12'h000;
    if (active) begin
      unique case (disp_state_q)
        ST_ENDING: rgb_d = 12'h00F;
        ST_HIT:    rgb_d = flash_on ? 12'hFF0 : (in_border ? 12'h0F0 : 12'h000);
        ST_FAIL:   rgb_d = flash_on ? 12'hF00 : (in_border ? 12'h0F0 : 12'h000);
        default:   rgb_d = in_border ? 12'h0F0 : 12'h000;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp_state_q  <= ST_ENDING;
      flash_cnt_q   <= '0;
      frame_start_q <= 1'b0;
      rgb_q         <= 12'h000;
    end else begin
      disp_state_q  <= disp_state_d;
      flash_cnt_q   <= flash_cnt_d;
      frame_start_q <= frame_end;
      if (pix_en) begin
        rgb_q <= rgb_d;
      end
    end
  end

  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_status_display.sv
// ============================================================================
// Module   : tb_vga_status_display
// Purpose  : Directed + randomized bench against a pixel-position reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_status_display;

  localparam int HA = 16, HF = 2, HS = 4, HB = 2;
  localparam int VA = 12, VF = 2, VS = 2, VB = 2;
  localparam int BP = 2;
  localparam int FF = 14;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] res   = 2'd1;
  logic       hsync, vsync, frame_start;
  logic [3:0] vga_r, vga_g, vga_b;

  int n_cmp  = 0;
  int n_fail = 0;
  int edges  = 0;
  int m_state = 3;
  int m_flash = 0;
  int hs_low = 0;
  int vs_low = 0;

  vga_status_display #(
    .FLASH_FRAMES (FF),
    .BORDER_PX    (BP),
    .H_ACTIVE     (HA),
    .H_FRONT      (HF),
    .H_SYNC       (HS),
    .H_BACK       (HB),
    .V_ACTIVE     (VA),
    .V_FRONT      (VF),
    .V_SYNC       (VS),
    .V_BACK       (VB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .result      (res),
    .hsync       (hsync),
    .vsync       (vsync),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .frame_start (frame_start)
  );

  always #10 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [14:0] observed();
    return {hsync, vsync, frame_start, vga_r, vga_g, vga_b};
  endfunction

  task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_colour(input int h, input int v);
    logic flash, border;
    if (h >= HA || v >= VA) return 12'h000;
    flash  = (m_flash > 0) && (((m_flash / 4) % 2) == 1);
    border = (h < BP) || (h >= HA - BP) || (v < BP) || (v >= VA - BP);
    case (m_state)
      3:       return 12'h00F;
      0:       return flash ? 12'hFF0 : (border ? 12'h0F0 : 12'h000);
      2:       return flash ? 12'hF00 : (border ? 12'h0F0 : 12'h000);
      default: return border ? 12'h0F0 : 12'h000;
    endcase
  endfunction

  // One clock: outputs after k pixel advances show screen position k-1.
  task automatic tick();
    int k, q, h, v;
    logic fs, hs, vs;
    logic [11:0] c;
    @(posedge clock);
    edges++;
    @(negedge clock);
    k  = edges / 2;
    fs = 1'b0;
    if ((edges % 2 == 0) && (k > 0) && (k % FT == 0)) begin
      fs = 1'b1;
      if ((res == 2'd0 || res == 2'd2) && (int'(res) != m_state)) m_flash = FF;
      else if (m_flash > 0) m_flash--;
      m_state = int'(res);
    end
    if (k == 0) begin
      check("pixel", observed(), {1'b1, 1'b1, fs, 12'h000});
    end else begin
      q  = (k - 1) % FT;
      h  = q % HT;
      v  = q / HT;
      hs = !(h >= HA + HF && h < HA + HF + HS);
      vs = !(v >= VA + VF && v < VA + VF + VS);
      c  = model_colour(h, v);
      check("pixel", observed(), {hs, vs, fs, c});
      if ((edges % 2 == 0) && ((k - 1) / FT == 1)) begin
        hs_low += int'(!hsync);
        vs_low += int'(!vsync);
      end
    end
  endtask

  function automatic int kpos(input int f, input int h, input int v);
    return f * FT + v * HT + h + 1;
  endfunction

  task automatic run_to_k(input int target);
    while (edges < 2 * target) tick();
  endtask

  task automatic check_rgb(input string tag, input logic [11:0] exp);
    check(tag, {3'b000, vga_r, vga_g, vga_b}, {3'b000, exp});
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("reset_state", observed(), {1'b1, 1'b1, 1'b0, 12'h000});
    reset = 1'b1;

    run_to_k(kpos(0, 5, 5));
    check_rgb("frame0_ending_blue", 12'h00F);

    run_to_k(kpos(1, 0, 0));
    check_rgb("run_px_0_0_green", 12'h0F0);
    run_to_k(kpos(1, 8, 6));
    check_rgb("run_centre_black", 12'h000);
    run_to_k(kpos(1, HA + 2, 1));
    check_rgb("run_blanking_black", 12'h000);

    run_to_k(kpos(2, 0, 0));
    check("hsync_low_pixels", {5'd0, 10'(hs_low)}, {5'd0, 10'(HS * VT)});
    check("vsync_low_pixels", {5'd0, 10'(vs_low)}, {5'd0, 10'(VS * HT)});

    run_to_k(kpos(2, 8, 6));
    res = 2'd0;
    run_to_k(kpos(2, 9, 6));
    check_rgb("midframe_change_held", 12'h000);
    run_to_k(kpos(3, 8, 6));
    check_rgb("hit_flash_yellow", 12'hFF0);

    run_to_k(kpos(4, 8, 6));
    check_rgb("hit_flash_frame2", 12'hFF0);
    res = 2'd2;
    run_to_k(kpos(5, 8, 6));
    check_rgb("fail_replaces_hit", 12'hF00);
    run_to_k(kpos(6, 8, 6));
    check_rgb("fail_reload_hold", 12'hF00);
    run_to_k(kpos(8, 8, 6));
    check_rgb("fail_flash_off_phase", 12'h000);

    for (int f = 9; f < 19; f++) begin
      run_to_k(kpos(f, int'($urandom_range(0, HT - 1)), int'($urandom_range(0, VT - 1))));
      res = 2'($urandom_range(0, 2));
    end

    run_to_k(kpos(19, 8, 6));
    res = 2'd3;
    run_to_k(kpos(40, 8, 6));
    check_rgb("ending_blue_mid", 12'h00F);
    run_to_k(kpos(60, 8, 6));
    check_rgb("ending_blue_40_frames", 12'h00F);

    run_to_k(kpos(61, 0, 0));
    res = 2'd2;
    run_to_k(kpos(62, 8, 6));
    check_rgb("pre_reset_red", 12'hF00);
    reset = 1'b0;
    #1;
    check("reset_async_outputs", observed(), {1'b1, 1'b1, 1'b0, 12'h000});
    res = 2'd0;
    repeat (3) @(negedge clock);
    check("reset_held_outputs", observed(), {1'b1, 1'b1, 1'b0, 12'h000});
    edges   = 0;
    m_state = 3;
    m_flash = 0;
    reset   = 1'b1;

    run_to_k(kpos(0, 8, 6));
    check_rgb("post_reset_blue", 12'h00F);
    run_to_k(kpos(1, 8, 6));
    check_rgb("post_reset_hit_yellow", 12'hFF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_status_display.md
VGA_STATUS_DISPLAY -- requirements
Module: vga_status_display

Interface
REQ-001 SHALL have port: clock  input  1  50 MHz system clock; sole clock domain.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: result  input  2  game status code; running=1, hit=0, fail=2, ending=3.
REQ-004 SHALL have port: hsync  output  1  VGA horizontal sync, active-low.
REQ-005 SHALL have port: vsync  output  1  VGA vertical sync, active-low.
REQ-006 SHALL have ports: vga_r, vga_g, vga_b  output  4 each  pixel colour.
REQ-007 SHALL have port: frame_start  output  1  one-clock pulse when a new frame's status is latched.
REQ-008 SHALL have parameter: FLASH_FRAMES, default 30, number of frames a hit or fail flash lasts.
REQ-009 SHALL have parameter: BORDER_PX, default 16, width of the running-state border in pixels.

Function
REQ-010 SHALL generate pix_en, high on every second clock (25 MHz); all counters advance only when pix_en=1.
REQ-011 SHALL count h_cnt 0..799 and wrap to 0; v_cnt SHALL increment on h_cnt wrap, range 0..524, and wrap to 0.
REQ-012 SHALL drive hsync low for h_cnt 656..751 and vsync low for v_cnt 490..491; both high otherwise.
REQ-013 SHALL treat the active region as h_cnt<640 and v_cnt<480; RGB SHALL be 0 outside it.
REQ-014 SHALL sample result into disp_state only on the pix_en cycle with h_cnt=799 and v_cnt=524; mid-frame changes of result SHALL NOT affect the current frame.
REQ-015 SHALL pulse frame_start on the clock after that sample.
REQ-016 SHALL load flash_cnt=FLASH_FRAMES when the sampled code is hit or fail and differs from the previous disp_state; otherwise flash_cnt SHALL decrement once per frame, saturating at 0.
REQ-017 SHALL restart flash_cnt at FLASH_FRAMES on a direct change between hit and fail.
REQ-018 SHALL compute flash_on as bit 2 of flash_cnt (period 8 frames), forced 0 when flash_cnt=0.
REQ-019 SHALL render running: green (0,F,0) where h<BORDER_PX, h>=640-BORDER_PX, v<BORDER_PX or v>=480-BORDER_PX; black interior.
REQ-020 SHALL render hit: yellow (F,F,0) full-screen when flash_on=1, else running rendering.
REQ-021 SHALL render fail: red (F,0,0) full-screen when flash_on=1, else running rendering.
REQ-022 SHALL render ending: blue (0,0,F) full-screen, no flashing.
REQ-023 SHALL register hsync, vsync and RGB so they lag their h_cnt/v_cnt position by exactly one pix_en cycle.

Reset
REQ-024 SHALL, on reset low, asynchronously clear h_cnt, v_cnt, pix_en and flash_cnt, set disp_state=ending(3), drive hsync=1, vsync=1, RGB=0 and frame_start=0.
REQ-025 SHALL restart from h_cnt=0, v_cnt=0 on reset release, with the first status sample at the end of the first full frame.
REQ-026 SHALL abandon any flash or partial frame in progress when reset is asserted.

Structure
REQ-027 SHALL place the status codes (running/hit/fail/ending) and the VGA 640x480 timing constants in a shared package used by both the status producer and this block.
REQ-028 SHALL instantiate one sub-module, vga_timing, that owns pix_en, h_cnt, v_cnt, the sync signals and the active flag; colour and flash logic SHALL stay in the top module.

Verification
REQ-029 SHALL cover: reset release -> hsync low for exactly 96 pixels per 800-pixel line, vsync low for 2 of 525 lines, both measured in pix_en cycles.
REQ-030 SHALL cover: result=1 held -> pixel (0,0) green, pixel (320,240) black, pixel (700,10) black (blanking).
REQ-031 SHALL cover: result 1->0 mid-frame -> no change until the next frame_start; then pixel (320,240) yellow for frames where flash_cnt bit2=1, and green border only after 30 frames.
REQ-032 SHALL cover: result 0->2 during a hit flash -> flash_cnt reloads to 30 at the next sample and red replaces yellow.
REQ-033 SHALL cover: result=3 -> every active pixel (0,0,F) and no flashing over 40 frames.
REQ-034 SHALL cover: reset asserted at h_cnt=400, v_cnt=200 -> outputs go to reset values immediately, and disp_state=3 (blue) is displayed after release.
